// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
// Write-back stage and architectural register file of the 5-stage pipeline.
// Picks the write-back value (load data or ALU result), commits it to a
// 2**ADDR_W entry register file, and serves the two ID-stage read ports with
// a same-cycle write-to-read bypass. It also keeps a registered record of the
// last committed write and a counter of committed writes for debug.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   MemtoReg_i    1 = write back dmem_rdata_i, 0 = write back ALUoutput_i
//   RegWrite_i    write-back enable from MEM/WB
//   dmem_rdata_i  load data from MEM/WB
//   ALUoutput_i   ALU result from MEM/WB
//   reg_dst_i     destination register index
//   rs_addr_i     read port A index
//   rt_addr_i     read port B index
//   rs_data_o     read port A data (combinational, bypassed)
//   rt_data_o     read port B data (combinational, bypassed)
//   wb_data_o     selected write-back data (combinational)
//   last_dst_o    index of the last committed write
//   last_data_o   data of the last committed write
//   wb_count_o    committed writes since reset, wraps modulo 2**CNT_W
// ---------------------------------------------------------------------------
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemtoReg_i,
    input  logic              RegWrite_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    input  logic [DATA_W-1:0] ALUoutput_i,
    input  logic [ADDR_W-1:0] reg_dst_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [ADDR_W-1:0] last_dst_o,
    output logic [DATA_W-1:0] last_data_o,
    output logic [CNT_W-1:0]  wb_count_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] r_regs;
    logic [ADDR_W-1:0]            r_lastDst;
    logic [DATA_W-1:0]            r_lastData;
    logic [CNT_W-1:0]             r_wbCount;

    logic [DATA_W-1:0]            w_wbData;
    logic                         w_commit;

    assign w_wbData = MemtoReg_i ? dmem_rdata_i : ALUoutput_i;

    // A write to r0 is dropped entirely, and nothing commits while reset is
    // held; this single qualifier gates storage, last_* and the counter, so an
    // X on MemtoReg_i with RegWrite_i low never reaches state.
    assign w_commit = rst && RegWrite_i && (reg_dst_i != '0);

    // Register file plus debug record. r0 is never written, so it stays at its
    // reset value of zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_regs     <= '0;
            r_lastDst  <= '0;
            r_lastData <= '0;
            r_wbCount  <= '0;
        end else if (w_commit) begin
            r_regs[reg_dst_i] <= w_wbData;
            r_lastDst         <= reg_dst_i;
            r_lastData        <= w_wbData;
            r_wbCount         <= r_wbCount + CNT_W'(1);
        end
    end

    // Read port A: zero during reset and for r0, otherwise the value being
    // committed this cycle wins over the stored one so ID sees it immediately.
    always_comb begin
        rs_data_o = r_regs[rs_addr_i];
        if (!rst || (rs_addr_i == '0)) begin
            rs_data_o = '0;
        end else if (w_commit && (rs_addr_i == reg_dst_i)) begin
            rs_data_o = w_wbData;
        end
    end

    // Read port B: same rule as port A.
    always_comb begin
        rt_data_o = r_regs[rt_addr_i];
        if (!rst || (rt_addr_i == '0)) begin
            rt_data_o = '0;
        end else if (w_commit && (rt_addr_i == reg_dst_i)) begin
            rt_data_o = w_wbData;
        end
    end

    assign wb_data_o   = w_wbData;
    assign last_dst_o  = r_lastDst;
    assign last_data_o = r_lastData;
    assign wb_count_o  = r_wbCount;

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
// Self-checking bench for wb_regfile. Two instances share every input: the
// default build and a CNT_W=4 build used to observe counter wrap. A directed
// vector table, a randomized phase against an array-based reference model,
// and hand-written reset and wrap sequences.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        memtoReg;
    logic        regWrite;
    logic [31:0] dmemRdata;
    logic [31:0] aluOutput;
    logic [4:0]  regDst;
    logic [4:0]  rsAddr;
    logic [4:0]  rtAddr;

    logic [31:0] rsData, rtData, wbData, lastData;
    logic [4:0]  lastDst;
    logic [31:0] wbCount;

    logic [31:0] rsDataS, rtDataS, wbDataS, lastDataS;
    logic [4:0]  lastDstS;
    logic [3:0]  wbCountS;

    int testsRun = 0;
    int failures = 0;

    // Reference model: architectural state as the instruction set sees it.
    logic [31:0] modelRegs [32];
    logic [4:0]  modelLastDst;
    logic [31:0] modelLastData;
    logic [31:0] modelCount;

    typedef struct {
        logic        m;
        logic        w;
        logic [31:0] dmem;
        logic [31:0] alu;
        logic [4:0]  dst;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] expRs;
        logic [31:0] expRt;
        logic [31:0] expWb;
        logic [4:0]  expLastDst;
        logic [31:0] expLastData;
        logic [31:0] expCount;
    } vec_t;

    vec_t vecs [10];

    wb_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .MemtoReg_i   (memtoReg),
        .RegWrite_i   (regWrite),
        .dmem_rdata_i (dmemRdata),
        .ALUoutput_i  (aluOutput),
        .reg_dst_i    (regDst),
        .rs_addr_i    (rsAddr),
        .rt_addr_i    (rtAddr),
        .rs_data_o    (rsData),
        .rt_data_o    (rtData),
        .wb_data_o    (wbData),
        .last_dst_o   (lastDst),
        .last_data_o  (lastData),
        .wb_count_o   (wbCount)
    );

    wb_regfile #(.CNT_W(4)) dutSmall (
        .clk          (clk),
        .rst          (rst),
        .MemtoReg_i   (memtoReg),
        .RegWrite_i   (regWrite),
        .dmem_rdata_i (dmemRdata),
        .ALUoutput_i  (aluOutput),
        .reg_dst_i    (regDst),
        .rs_addr_i    (rsAddr),
        .rt_addr_i    (rtAddr),
        .rs_data_o    (rsDataS),
        .rt_data_o    (rtDataS),
        .wb_data_o    (wbDataS),
        .last_dst_o   (lastDstS),
        .last_data_o  (lastDataS),
        .wb_count_o   (wbCountS)
    );

    // Free-running 10 time-unit clock; inputs change on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic m, input logic w, input logic [31:0] d,
                                 input logic [31:0] a, input logic [4:0] dst,
                                 input logic [4:0] rs, input logic [4:0] rt);
        @(negedge clk);
        memtoReg  = m;
        regWrite  = w;
        dmemRdata = d;
        aluOutput = a;
        regDst    = dst;
        rsAddr    = rs;
        rtAddr    = rt;
        #1;
    endtask

    task automatic clearModel();
        for (int i = 0; i < 32; i++) modelRegs[i] = '0;
        modelLastDst  = '0;
        modelLastData = '0;
        modelCount    = '0;
    endtask

    function automatic logic [31:0] refWb();
        return memtoReg ? dmemRdata : aluOutput;
    endfunction

    function automatic logic willCommit();
        return rst && regWrite && (regDst != 5'd0);
    endfunction

    // What an ID-stage read should return this cycle.
    function automatic logic [31:0] refRead(input logic [4:0] addr);
        if (!rst || addr == 5'd0) return 32'h0;
        if (willCommit() && addr == regDst) return refWb();
        return modelRegs[addr];
    endfunction

    // Advance one rising edge, applying the commit to the model.
    task automatic clockEdge();
        logic        c;
        logic [31:0] v;
        c = willCommit();
        v = refWb();
        @(posedge clk);
        if (c) begin
            modelRegs[regDst] = v;
            modelLastDst      = regDst;
            modelLastData     = v;
            modelCount        = modelCount + 32'd1;
        end
        #1;
    endtask

    task automatic checkModelComb(input string tag);
        checkOutput({tag, ".rs"}, rsData, refRead(rsAddr));
        checkOutput({tag, ".rt"}, rtData, refRead(rtAddr));
        checkOutput({tag, ".wb"}, wbData, refWb());
        checkOutput({tag, ".rsS"}, rsDataS, refRead(rsAddr));
    endtask

    task automatic checkModelRegs(input string tag);
        checkOutput({tag, ".lastDst"}, {27'd0, lastDst}, {27'd0, modelLastDst});
        checkOutput({tag, ".lastData"}, lastData, modelLastData);
        checkOutput({tag, ".count"}, wbCount, modelCount);
        checkOutput({tag, ".count4"}, {28'd0, wbCountS}, {28'd0, modelCount[3:0]});
    endtask

    initial begin
        vec_t v;
        logic [4:0] d;
        logic [31:0] expSmall;

        // Directed vectors from a freshly reset file, in execution order.
        vecs[0] = '{1'b0, 1'b1, 32'h0,        32'h0000_1234, 5'd8, 5'd0, 5'd8,
                    32'h0,        32'h1234,     32'h1234,     5'd8, 32'h1234,     32'd1};
        vecs[1] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 32'h55,       5'd9, 5'd9, 5'd9,
                    32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd9, 32'hDEAD_BEEF, 32'd2};
        vecs[2] = '{1'b0, 1'b0, 32'h0,        32'h0,         5'd0, 5'd9, 5'd8,
                    32'hDEAD_BEEF, 32'h1234,     32'h0,        5'd9, 32'hDEAD_BEEF, 32'd2};
        vecs[3] = '{1'b0, 1'b1, 32'h0,        32'hFFFF_FFFF, 5'd0, 5'd0, 5'd9,
                    32'h0,        32'hDEAD_BEEF, 32'hFFFF_FFFF, 5'd9, 32'hDEAD_BEEF, 32'd2};
        vecs[4] = '{1'b0, 1'b1, 32'h0,        32'h33,        5'd3, 5'd3, 5'd0,
                    32'h33,       32'h0,        32'h33,       5'd3, 32'h33,       32'd3};
        vecs[5] = '{1'b0, 1'b0, 32'h0,        32'h7,         5'd3, 5'd3, 5'd3,
                    32'h33,       32'h33,       32'h7,        5'd3, 32'h33,       32'd3};
        vecs[6] = '{1'bx, 1'b0, 32'hAB,       32'hAB,        5'd3, 5'd3, 5'd8,
                    32'h33,       32'h1234,     32'hAB,       5'd3, 32'h33,       32'd3};
        vecs[7] = '{1'b0, 1'b1, 32'h0,        32'h100,       5'd4, 5'd4, 5'd4,
                    32'h100,      32'h100,      32'h100,      5'd4, 32'h100,      32'd4};
        vecs[8] = '{1'b1, 1'b1, 32'h200,      32'h0,         5'd4, 5'd4, 5'd0,
                    32'h200,      32'h0,        32'h200,      5'd4, 32'h200,      32'd5};
        vecs[9] = '{1'b0, 1'b0, 32'h0,        32'h0,         5'd0, 5'd4, 5'd9,
                    32'h200,      32'hDEAD_BEEF, 32'h0,        5'd4, 32'h200,      32'd5};

        // Power-up under reset: an active write must not leak into any output.
        rst = 1'b0;
        memtoReg = 1'b0; regWrite = 1'b1; dmemRdata = 32'h0; aluOutput = 32'hA5A5_A5A5;
        regDst = 5'd5; rsAddr = 5'd5; rtAddr = 5'd7;
        clearModel();
        #2;
        checkOutput("por.rs", rsData, 32'h0);
        checkOutput("por.rt", rtData, 32'h0);
        checkOutput("por.count", wbCount, 32'h0);
        checkOutput("por.lastData", lastData, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("por.noCommit", wbCount, 32'h0);
        @(negedge clk);
        regWrite = 1'b0;
        rst = 1'b1;

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            applyStimulus(v.m, v.w, v.dmem, v.alu, v.dst, v.rs, v.rt);
            checkOutput($sformatf("vec%0d.rs", i), rsData, v.expRs);
            checkOutput($sformatf("vec%0d.rt", i), rtData, v.expRt);
            checkOutput($sformatf("vec%0d.wb", i), wbData, v.expWb);
            clockEdge();
            checkOutput($sformatf("vec%0d.lastDst", i), {27'd0, lastDst}, {27'd0, v.expLastDst});
            checkOutput($sformatf("vec%0d.lastData", i), lastData, v.expLastData);
            checkOutput($sformatf("vec%0d.count", i), wbCount, v.expCount);
            checkOutput($sformatf("vec%0d.count4", i), {28'd0, wbCountS}, {28'd0, v.expCount[3:0]});
        end

        // Randomized traffic against the reference model, biased toward bypass hits.
        for (int i = 0; i < 300; i++) begin
            d = 5'($urandom_range(0, 31));
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                          $urandom, $urandom, d,
                          ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)),
                          ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)));
            checkModelComb("rand");
            clockEdge();
            checkModelRegs("rand");
        end

        // Reset asserted mid-cycle while a write to r5 is pending.
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h5555_5555, 5'd5, 5'd5, 5'd9);
        rst = 1'b0;
        #1;
        clearModel();
        checkOutput("midRst.rs", rsData, 32'h0);
        checkOutput("midRst.rt", rtData, 32'h0);
        checkOutput("midRst.count", wbCount, 32'h0);
        checkOutput("midRst.count4", {28'd0, wbCountS}, 32'h0);
        checkOutput("midRst.lastDst", {27'd0, lastDst}, 32'h0);
        checkOutput("midRst.lastData", lastData, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        regWrite = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("midRst.r5", rsData, 32'h0);
        checkOutput("midRst.r9", rtData, 32'h0);
        checkOutput("midRst.countAfter", wbCount, 32'h0);

        // 17 commits to r1..r17: the 4-bit counter must read 15, 0, 1 at the end.
        for (int i = 1; i <= 17; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h0, 32'(i) * 32'h11, 5'(i), 5'd0, 5'd0);
            clockEdge();
            checkOutput($sformatf("wrap%0d.count", i), wbCount, 32'(i));
            if (i >= 15) begin
                expSmall = (i == 15) ? 32'd15 : ((i == 16) ? 32'd0 : 32'd1);
                checkOutput($sformatf("wrap%0d.count4", i), {28'd0, wbCountS}, expSmall);
            end
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd17, 5'd16);
        checkOutput("wrap.r17", rsData, 32'd17 * 32'h11);
        checkOutput("wrap.r16", rtData, 32'd16 * 32'h11);
        checkOutput("wrap.r17small", rsDataS, 32'd17 * 32'h11);
        checkOutput("wrap.lastData", lastDataS, 32'd17 * 32'h11);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage and architectural register file of the 5-stage pipelined CPU.
- Consumes the MEM/WB pipeline register outputs and selects the write-back data (load data or ALU result).
- Commits that data to a 32-entry register file and serves the two ID-stage read ports, with same-cycle write-to-read bypass.
- Keeps a registered record of the last committed write and a retired-write counter for debug and verification.

Parameters:
- DATA_W, 32, register/data width
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- CNT_W, 32, width of retired-write counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- MemtoReg_i  input  1  1 = write back dmem_rdata_i, 0 = write back ALUoutput_i
- RegWrite_i  input  1  write-back enable from MEM/WB
- dmem_rdata_i  input  DATA_W  load data from MEM/WB
- ALUoutput_i  input  DATA_W  ALU result from MEM/WB
- reg_dst_i  input  ADDR_W  destination register index from MEM/WB
- rs_addr_i  input  ADDR_W  read port A index (ID stage)
- rt_addr_i  input  ADDR_W  read port B index (ID stage)
- rs_data_o  output  DATA_W  read port A data (combinational)
- rt_data_o  output  DATA_W  read port B data (combinational)
- wb_data_o  output  DATA_W  selected write-back data (combinational, to forwarding unit)
- last_dst_o  output  ADDR_W  index of last committed write (registered)
- last_data_o  output  DATA_W  data of last committed write (registered)
- wb_count_o  output  CNT_W  number of committed writes since reset (registered)

Behaviour:
- Reset: rst low asynchronously clears all 32 registers, last_dst_o, last_data_o and wb_count_o to 0. Reset has priority over any write in flight. While rst is low, rs_data_o and rt_data_o read 0 and no write commits regardless of RegWrite_i.
- WB select: wb_data_o = MemtoReg_i ? dmem_rdata_i : ALUoutput_i, purely combinational.
- Commit condition: rst high AND RegWrite_i = 1 AND reg_dst_i != 0.
- On a commit at the rising edge:
  - reg[reg_dst_i] <= wb_data_o
  - last_dst_o <= reg_dst_i
  - last_data_o <= wb_data_o
  - wb_count_o <= wb_count_o + 1
- No commit means no state changes.
- Register 0:
  - Always reads 0.
  - A write with reg_dst_i = 0 is discarded: no storage update, no counter increment, last_* unchanged.
- Read ports are combinational, so latency is zero.
- Bypass: if the commit condition is true and rs_addr_i == reg_dst_i, then rs_data_o = wb_data_o in the same cycle. rt_data_o uses the same rule. This resolves the WB/ID same-cycle hazard without a split-phase clock.
- Both ports may read the same index; both ports may hit the bypass simultaneously.
- Counter wraps modulo 2**CNT_W; all-ones + 1 = 0, with no saturation and no flag.
- Back-to-back writes to the same index: each cycle's commit overwrites the previous one. A read in the second cycle sees the second value via bypass.
- X on MemtoReg_i when RegWrite_i = 0 must not corrupt state.

Test Plan:
- Reset: drive rst low mid-cycle while RegWrite_i=1, reg_dst_i=5 -> all reads 0, wb_count_o=0 immediately, reg 5 stays 0 after rst releases.
- ALU write-back: RegWrite_i=1, MemtoReg_i=0, ALUoutput_i=0x0000_1234, reg_dst_i=8 -> after edge rt_addr_i=8 reads 0x1234, last_dst_o=8, last_data_o=0x1234, wb_count_o=1.
- Load write-back with bypass: MemtoReg_i=1, dmem_rdata_i=0xDEAD_BEEF, reg_dst_i=9, rs_addr_i=rt_addr_i=9 in the same cycle -> both ports read 0xDEADBEEF before the edge, and again after it.
- r0 discard: RegWrite_i=1, reg_dst_i=0, ALUoutput_i=0xFFFF_FFFF -> rs_addr_i=0 reads 0 (also in the same cycle), wb_count_o and last_* unchanged.
- Disabled write: RegWrite_i=0, reg_dst_i=3, ALUoutput_i=7 -> reg 3 unchanged, no bypass (rs_addr_i=3 returns the stored value), wb_count_o unchanged.
- Counter wrap (CNT_W=4 build): 17 commits to r1..r17 -> wb_count_o sequence ends 15, 0, 1; r17 holds the last data.
